// File: rtl/stack_ck_if.sv
// Bundle of the stack_ck control, data and status signals.
// The master side drives moves and write data; the slave side is the stack.
interface stack_ck_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 18
);
  localparam int DW = $clog2(DEPTH + 2);

  logic             we;
  logic [1:0]       delta;
  logic [WIDTH-1:0] wd;
  logic             clr_err;
  logic [WIDTH-1:0] rd;
  logic [WIDTH-1:0] nos;
  logic [DW-1:0]    depth;
  logic             empty;
  logic             full;
  logic             ovf;
  logic             unf;

  modport master (
    output we, delta, wd, clr_err,
    input  rd, nos, depth, empty, full, ovf, unf
  );

  modport slave (
    input  we, delta, wd, clr_err,
    output rd, nos, depth, empty, full, ovf, unf
  );
endinterface

// File: rtl/stack_ck.sv
// J1-style stack with a head register over a shift-register tail, plus a
// depth counter, full/empty status and sticky overflow/underflow flags.
module stack_ck #(
  parameter int               WIDTH = 16,
  parameter int               DEPTH = 18,
  parameter logic [WIDTH-1:0] FILL  = WIDTH'(16'h55aa)
) (
  input logic        clk,
  input logic        reset,
  stack_ck_if.slave  bus
);
  localparam int            DW   = $clog2(DEPTH + 2);
  localparam logic [DW-1:0] MAXD = DW'(DEPTH + 1);

  generate
    if (DEPTH < 2) begin : g_depth_chk
      $error("stack_ck: DEPTH must be at least 2 for pop-two");
    end
  endgenerate

  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail [DEPTH];
  logic [DW-1:0]    cnt;
  logic             ovf_q;
  logic             unf_q;
  logic             ovf_evt;
  logic             unf_evt;

  always_comb begin
    ovf_evt = 1'b0;
    unf_evt = 1'b0;
    case (bus.delta)
      2'b01:   ovf_evt = (cnt == MAXD);
      2'b11:   unf_evt = (cnt == '0);
      2'b10:   unf_evt = (cnt < DW'(2));
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) tail[i] <= FILL;
      cnt   <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      // Set beats clear when an error event coincides with clr_err.
      ovf_q <= (ovf_q & ~bus.clr_err) | ovf_evt;
      unf_q <= (unf_q & ~bus.clr_err) | unf_evt;
      case (bus.delta)
        2'b00: begin
          if (bus.we) head <= bus.wd;
        end
        2'b01: begin
          head    <= bus.we ? bus.wd : tail[0];
          tail[0] <= head;
          for (int unsigned i = 0; i < DEPTH - 1; i++) tail[i+1] <= tail[i];
          if (cnt != MAXD) cnt <= cnt + 1'b1;
        end
        2'b11: begin
          head <= bus.we ? bus.wd : tail[0];
          for (int unsigned i = 0; i < DEPTH - 1; i++) tail[i] <= tail[i+1];
          tail[DEPTH-1] <= FILL;
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        default: begin
          head <= bus.we ? bus.wd : tail[1];
          for (int unsigned i = 0; i < DEPTH - 2; i++) tail[i] <= tail[i+2];
          tail[DEPTH-2] <= FILL;
          tail[DEPTH-1] <= FILL;
          cnt <= (cnt >= DW'(2)) ? cnt - DW'(2) : '0;
        end
      endcase
    end
  end

  assign bus.rd    = head;
  assign bus.nos   = tail[0];
  assign bus.depth = cnt;
  assign bus.empty = (cnt == '0);
  assign bus.full  = (cnt == MAXD);
  assign bus.ovf   = ovf_q;
  assign bus.unf   = unf_q;
endmodule

// File: tb/tb_stack_ck.sv
// Directed and randomized checks of stack_ck against a queue-based model of
// the stack contents, depth and sticky flags.
module tb_stack_ck;
  localparam int               W  = 16;
  localparam int               D  = 18;
  localparam logic [W-1:0]     F  = 16'h55aa;
  localparam int               DW = $clog2(D + 2);

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  stack_ck_if #(.WIDTH(W), .DEPTH(D)) bus ();

  stack_ck #(.WIDTH(W), .DEPTH(D), .FILL(F)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model: q[0] is the top of stack, q[1] next on stack; always D+1 entries.
  logic [W-1:0] q[$];
  int md;
  bit mo, mu;

  function automatic void model_reset();
    q.delete();
    q.push_back('0);
    for (int i = 0; i < D; i++) q.push_back(F);
    md = 0;
    mo = 0;
    mu = 0;
  endfunction

  function automatic void model_apply(input bit we, input bit [1:0] dl,
                                      input logic [W-1:0] wd, input bit clr);
    logic [W-1:0] top;
    if (clr) begin
      mo = 0;
      mu = 0;
    end
    case (dl)
      2'b00: if (we) q[0] = wd;
      2'b01: begin
        top = we ? wd : q[1];
        q.push_front(top);
        void'(q.pop_back());
        if (md < D + 1) md++; else mo = 1;
      end
      2'b11: begin
        void'(q.pop_front());
        if (we) q[0] = wd;
        q.push_back(F);
        if (md > 0) md--; else mu = 1;
      end
      default: begin
        void'(q.pop_front());
        void'(q.pop_front());
        if (we) q[0] = wd;
        q.push_back(F);
        q.push_back(F);
        if (md >= 2) md -= 2; else begin md = 0; mu = 1; end
      end
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("rd",    32'(bus.rd),    32'(q[0]));
    chk("nos",   32'(bus.nos),   32'(q[1]));
    chk("depth", 32'(bus.depth), 32'(md));
    chk("empty", 32'(bus.empty), 32'(md == 0));
    chk("full",  32'(bus.full),  32'(md == D + 1));
    chk("ovf",   32'(bus.ovf),   32'(mo));
    chk("unf",   32'(bus.unf),   32'(mu));
  endtask

  task automatic step(input bit rst, input bit we, input bit [1:0] dl,
                      input logic [W-1:0] wd, input bit clr);
    reset       = rst;
    bus.we      = we;
    bus.delta   = dl;
    bus.wd      = wd;
    bus.clr_err = clr;
    if (rst) model_reset();
    else     model_apply(we, dl, wd, clr);
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    logic [W-1:0] nos_before;
    bit seen1;
    int r;

    bus.we = 0; bus.delta = 2'b00; bus.wd = '0; bus.clr_err = 0;
    model_reset();

    // Reset and idle
    step(1, 0, 2'b00, '0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 2'b00, '0, 0);
    chk("rst_rd", 32'(bus.rd), 32'h0);
    chk("rst_nos", 32'(bus.nos), 32'h55aa);
    chk("rst_empty", 32'(bus.empty), 32'h1);

    // Push 1..5 then two pops without write
    for (int i = 1; i <= 5; i++) step(0, 1, 2'b01, W'(i), 0);
    chk("push5_rd", 32'(bus.rd), 32'd5);
    chk("push5_nos", 32'(bus.nos), 32'd4);
    chk("push5_depth", 32'(bus.depth), 32'd5);
    for (int i = 0; i < 2; i++) step(0, 0, 2'b11, '0, 0);
    chk("pop2_rd", 32'(bus.rd), 32'd3);
    chk("pop2_nos", 32'(bus.nos), 32'd2);
    chk("pop2_depth", 32'(bus.depth), 32'd3);

    // Fill to capacity, overflow, drain
    step(1, 0, 2'b00, '0, 0);
    for (int i = 1; i <= 19; i++) step(0, 1, 2'b01, W'(i), 0);
    chk("cap_full", 32'(bus.full), 32'd1);
    chk("cap_depth", 32'(bus.depth), 32'd19);
    chk("cap_ovf", 32'(bus.ovf), 32'd0);
    step(0, 1, 2'b01, 16'd20, 0);
    chk("ovf_depth", 32'(bus.depth), 32'd19);
    chk("ovf_flag", 32'(bus.ovf), 32'd1);
    chk("ovf_rd", 32'(bus.rd), 32'd20);
    seen1 = 0;
    for (int i = 0; i < 19; i++) begin
      step(0, 0, 2'b11, '0, 0);
      if (bus.rd == 16'd1) seen1 = 1;
    end
    chk("drain_rd", 32'(bus.rd), 32'h55aa);
    chk("lost_bottom", 32'(seen1), 32'd0);
    chk("drain_depth", 32'(bus.depth), 32'd0);

    // Pop-two
    step(1, 0, 2'b00, '0, 0);
    step(0, 1, 2'b01, 16'd7, 0);
    step(0, 1, 2'b01, 16'd8, 0);
    step(0, 1, 2'b01, 16'd9, 0);
    step(0, 0, 2'b10, '0, 0);
    chk("popt_rd", 32'(bus.rd), 32'd7);
    chk("popt_depth", 32'(bus.depth), 32'd1);
    step(0, 0, 2'b10, '0, 0);
    chk("popt_unf", 32'(bus.unf), 32'd1);
    chk("popt_rd2", 32'(bus.rd), 32'h55aa);

    // Flag clearing; set beats clear
    step(0, 0, 2'b00, '0, 1);
    chk("clr_unf", 32'(bus.unf), 32'd0);
    step(0, 0, 2'b11, '0, 1);
    chk("clr_vs_set", 32'(bus.unf), 32'd1);

    // Hold-write, then reset overriding a push
    step(1, 0, 2'b00, '0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 2'b01, W'(16'h100 + i), 0);
    nos_before = bus.nos;
    step(0, 1, 2'b00, 16'hbeef, 0);
    chk("hold_rd", 32'(bus.rd), 32'hbeef);
    chk("hold_nos", 32'(bus.nos), 32'(nos_before));
    chk("hold_depth", 32'(bus.depth), 32'd4);
    step(1, 1, 2'b01, 16'h1234, 0);
    chk("rst_push_depth", 32'(bus.depth), 32'd0);
    chk("rst_push_rd", 32'(bus.rd), 32'd0);

    // Randomized: push-heavy phase, then pop-heavy phase
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 250; i++) begin
        bit [1:0] dl;
        r = int'($urandom_range(0, 9));
        if (ph == 0) dl = (r < 6) ? 2'b01 : (r < 8) ? 2'b11 : (r < 9) ? 2'b10 : 2'b00;
        else         dl = (r < 2) ? 2'b01 : (r < 5) ? 2'b11 : (r < 8) ? 2'b10 : 2'b00;
        step(($urandom_range(0, 79) == 0), bit'($urandom_range(0, 1)), dl,
             W'($urandom), ($urandom_range(0, 7) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
